// File: rtl/seven_segment_pkg.sv
// Shared glyph encodings and value-to-glyph decode for the multiplexed
// seven-segment scanner.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam int         SEG_DP    = 7;

  // Letters only appear in hex mode; in decimal mode values above 9 go dark.
  function automatic logic [6:0] glyph(input logic [3:0] value, input logic hex_mode);
    logic [6:0] g;
    case (value)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      4'hF:    g = SEG_F;
      default: g = SEG_BLANK;
    endcase
    return (value > 4'h9 && !hex_mode) ? SEG_BLANK : g;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_glyph_lut.sv
// Combinational 4-bit value to logical seven-segment glyph decoder.
module seg7_glyph_lut
  import seven_segment_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_mode,
  output logic [6:0] glyph_out
);

  assign glyph_out = glyph(value, hex_mode);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous input
// snapshot, leading-zero blanking and an anode dead time at each slot start.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int BLANK_CYCLES     = 1000,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   ENABLE,
  input  logic                    HEX_MODE,
  input  logic                    LZ_BLANK,
  output logic [7:0]              SEGMENT,
  output logic [NUM_DIGITS-1:0]   ANODE,
  output logic                    FRAME_TICK
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0]      LAST_DIV = DIV_W'(REFRESH_DIV - 1);
  localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]        div_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] dig_r;
  logic [NUM_DIGITS-1:0]   dp_r;
  logic [NUM_DIGITS-1:0]   en_r;
  logic                    hex_r;
  logic                    lz_r;

  logic                    terminal_s;
  logic                    past_blank_s;
  logic                    run_s;
  logic [NUM_DIGITS-1:0]   lz_vec_s;
  logic [3:0]              cur_val_s;
  logic                    cur_dp_s;
  logic                    cur_en_s;
  logic                    cur_lz_s;
  logic [6:0]              glyph_s;
  logic [7:0]              seg_s;
  logic [NUM_DIGITS-1:0]   anode_s;

  assign terminal_s = (div_cnt_r == LAST_DIV);

  // Slot prescaler and digit index.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt_r <= '0;
      idx_r     <= '0;
    end else if (terminal_s) begin
      div_cnt_r <= '0;
      idx_r     <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Input snapshot at the end of each frame, so a frame never shows mixed values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dig_r      <= '0;
      dp_r       <= '0;
      en_r       <= '0;
      hex_r      <= 1'b0;
      lz_r       <= 1'b0;
      FRAME_TICK <= 1'b0;
    end else if (terminal_s && idx_r == LAST_IDX) begin
      dig_r      <= DIGITS;
      dp_r       <= DP;
      en_r       <= ENABLE;
      hex_r      <= HEX_MODE;
      lz_r       <= LZ_BLANK;
      FRAME_TICK <= 1'b1;
    end else begin
      FRAME_TICK <= 1'b0;
    end
  end

  // Leading-zero run from the top digit; disabled digits are transparent to it.
  always_comb begin
    run_s    = 1'b1;
    lz_vec_s = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      if (en_r[d] && run_s && d != 0 && dig_r[4*d +: 4] == 4'd0) begin
        lz_vec_s[d] = 1'b1;
      end else if (en_r[d]) begin
        run_s = 1'b0;
      end else begin
        lz_vec_s[d] = 1'b0;
      end
    end
  end

  // Select the snapshot fields of the digit currently being scanned.
  always_comb begin
    cur_val_s = 4'd0;
    cur_dp_s  = 1'b0;
    cur_en_s  = 1'b0;
    cur_lz_s  = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      cur_val_s = cur_val_s | (dig_r[4*d +: 4] & {4{idx_r == IDX_W'(d)}});
      cur_dp_s  = cur_dp_s | (dp_r[d] & (idx_r == IDX_W'(d)));
      cur_en_s  = cur_en_s | (en_r[d] & (idx_r == IDX_W'(d)));
      cur_lz_s  = cur_lz_s | (lz_vec_s[d] & (idx_r == IDX_W'(d)));
    end
    cur_lz_s = cur_lz_s & lz_r;
  end

  seg7_glyph_lut u_lut (
    .value     (cur_val_s),
    .hex_mode  (hex_r),
    .glyph_out (glyph_s)
  );

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank_s = 1'b1;
    end else begin : g_blank
      assign past_blank_s = (32'(div_cnt_r) >= 32'(BLANK_CYCLES));
    end
  endgenerate

  // Logical segment and anode patterns for the current slot position.
  always_comb begin
    seg_s   = 8'h00;
    anode_s = '0;
    if (cur_en_s) begin
      seg_s[6:0]    = cur_lz_s ? SEG_BLANK : glyph_s;
      seg_s[SEG_DP] = cur_dp_s;
    end else begin
      seg_s = 8'h00;
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      anode_s[d] = past_blank_s && cur_en_s && (idx_r == IDX_W'(d));
    end
  end

  // Output registers; XOR with the off pattern applies pin polarity.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SEGMENT <= SEG_OFF;
      ANODE   <= AN_OFF;
    end else begin
      SEGMENT <= seg_s ^ SEG_OFF;
      ANODE   <= anode_s ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against a frame-position model.
module tb_seven_segment_scanner;

  localparam int N  = 4;
  localparam int DV = 8;
  localparam int BL = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] DIGITS = 16'h0000;
  logic [3:0]  DP = 4'h0;
  logic [3:0]  ENABLE = 4'h0;
  logic        HEX_MODE = 1'b0;
  logic        LZ_BLANK = 1'b0;
  logic [7:0]  SEGMENT;
  logic [3:0]  ANODE;
  logic        FRAME_TICK;

  int checks = 0;
  int fails  = 0;

  logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: cycle position since reset plus the frame snapshot.
  int          p;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_en;
  logic        s_hex, s_lz;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_tick;

  seven_segment_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(DV), .BLANK_CYCLES(BL),
    .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DIGITS(DIGITS), .DP(DP), .ENABLE(ENABLE),
    .HEX_MODE(HEX_MODE), .LZ_BLANK(LZ_BLANK), .SEGMENT(SEGMENT), .ANODE(ANODE),
    .FRAME_TICK(FRAME_TICK)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input int i);
    int msd;
    logic [3:0] v;
    logic [6:0] g;
    if (!s_en[i]) return 8'h00;
    v = s_dig[4*i +: 4];
    msd = -1;
    for (int d = N - 1; d >= 0; d--)
      if (msd < 0 && s_en[d] && s_dig[4*d +: 4] != 4'd0) msd = d;
    if (s_lz && i != 0 && v == 4'd0 && i > msd) g = 7'h00;
    else if (v >= 4'd10 && !s_hex) g = 7'h00;
    else g = gl[v];
    return {s_dp[i], g};
  endfunction

  // Model advance on each active edge (or reset).
  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      p = 0; s_dig = 16'h0; s_dp = 4'h0; s_en = 4'h0; s_hex = 1'b0; s_lz = 1'b0;
      exp_seg = 8'hFF; exp_an = 4'hF; exp_tick = 1'b0;
    end else begin
      int i, c;
      i = (p / DV) % N;
      c = p % DV;
      exp_seg  = ~model_seg(i);
      exp_an   = (c >= BL && s_en[i]) ? ~(4'b0001 << i) : 4'hF;
      exp_tick = (c == DV - 1 && i == N - 1);
      if (exp_tick) begin
        s_dig = DIGITS; s_dp = DP; s_en = ENABLE; s_hex = HEX_MODE; s_lz = LZ_BLANK;
      end
      p++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      chk("segment", SEGMENT, exp_seg);
      chk("anode", {4'h0, ANODE}, {4'h0, exp_an});
      chk("frame_tick", {7'h0, FRAME_TICK}, {7'h0, exp_tick});
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (FRAME_TICK !== 1'b1 && n < 100);
    if (FRAME_TICK !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL tick_timeout: got none expected FRAME_TICK within 100 cycles");
    end
  endtask

  // Wait for the next snapshot, then to frame position j (slot j/8, offset j%8).
  task automatic after_tick(input int j);
    int n;
    wait_tick(n);
    repeat (j + 1) @(negedge CLK);
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                        input logic hx, input logic lz);
    DIGITS = d; DP = dp; ENABLE = en; HEX_MODE = hx; LZ_BLANK = lz;
  endtask

  task automatic rand_in();
    logic [15:0] d;
    d = 16'($urandom);
    for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 0) d[4*k +: 4] = 4'h0;
    set_in(d, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_seg", SEGMENT, 8'hFF);
    chk("reset_anode", {4'h0, ANODE}, 8'h0F);
    chk("reset_tick", {7'h0, FRAME_TICK}, 8'h00);
    #1 RESET = 1'b0;
    wait_tick(n);
    chk("first_tick_gap", 8'(n), 8'd32);
    wait_tick(n);
    chk("second_tick_gap", 8'(n), 8'd32);

    set_in(16'h1234, 4'b0100, 4'hF, 1'b0, 1'b0);
    after_tick(0);
    chk("d0_blank_anode", {4'h0, ANODE}, 8'h0F);
    chk("d0_blank_seg", SEGMENT, ~8'h66);
    repeat (2) @(negedge CLK);
    chk("d0_seg", SEGMENT, ~8'h66);
    chk("d0_anode", {4'h0, ANODE}, 8'h0E);
    repeat (16) @(negedge CLK);
    chk("d2_dp_seg", SEGMENT, ~8'hDB);
    chk("d2_anode", {4'h0, ANODE}, 8'h0B);

    set_in(16'hABCD, 4'h0, 4'hF, 1'b1, 1'b0);
    after_tick(2);
    chk("hex_d0", SEGMENT, ~8'h5E);
    repeat (24) @(negedge CLK);
    chk("hex_d3", SEGMENT, ~8'h77);
    set_in(16'hABCD, 4'h0, 4'hF, 1'b0, 1'b0);
    after_tick(2);
    chk("dec_over9_seg", SEGMENT, 8'hFF);
    chk("dec_over9_anode", {4'h0, ANODE}, 8'h0E);

    set_in(16'h0050, 4'h0, 4'hF, 1'b0, 1'b1);
    after_tick(2);
    chk("lz_d0", SEGMENT, ~8'h3F);
    repeat (8) @(negedge CLK);
    chk("lz_d1", SEGMENT, ~8'h6D);
    repeat (16) @(negedge CLK);
    chk("lz_d3", SEGMENT, 8'hFF);
    chk("lz_d3_anode", {4'h0, ANODE}, 8'h07);
    set_in(16'h0000, 4'h0, 4'hF, 1'b0, 1'b1);
    after_tick(2);
    chk("lz_zero_d0", SEGMENT, ~8'h3F);
    repeat (8) @(negedge CLK);
    chk("lz_zero_d1", SEGMENT, 8'hFF);

    set_in(16'h1234, 4'h0, 4'hF, 1'b0, 1'b0);
    after_tick(2);
    DIGITS = 16'h8888;
    repeat (8) @(negedge CLK);
    chk("midframe_hold", SEGMENT, ~8'h4F);

    set_in(16'h1234, 4'hF, 4'b0101, 1'b0, 1'b0);
    after_tick(10);
    chk("disabled_seg", SEGMENT, 8'hFF);
    chk("disabled_anode", {4'h0, ANODE}, 8'h0F);

    for (int k = 0; k < 1500; k++) begin
      @(negedge CLK);
      if ($urandom_range(0, 9) == 0) rand_in();
    end

    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("midslot_reset_seg", SEGMENT, 8'hFF);
    chk("midslot_reset_anode", {4'h0, ANODE}, 8'h0F);
    chk("midslot_reset_tick", {7'h0, FRAME_TICK}, 8'h00);
    @(negedge CLK);
    #1 RESET = 1'b0;
    wait_tick(n);
    chk("post_reset_tick_gap", 8'(n), 8'd32);
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) rand_in();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised multiplexed driver for an N-digit common-anode/cathode seven-segment display, replacing per-digit static decoding. Takes a packed BCD/hex digit vector plus per-digit decimal-point and enable masks and time-multiplexes them onto one shared SEGMENT bus and one-hot ANODE lines. Adds hex/decimal mode, leading-zero blanking, an anti-ghosting dead time, and frame-synchronous input snapshotting so counter updates never tear mid-frame. Sits between the timer counter logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clock cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 1000, cycles at start of each slot with all anodes inactive (0 allowed)
SEG_ACTIVE_LOW, 1, 1 = SEGMENT pins driven inverted
ANODE_ACTIVE_LOW, 1, 1 = ANODE pins driven inverted

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
DIGITS  input  4*NUM_DIGITS  packed digit values, [3:0] = digit 0 (rightmost, least significant)
DP  input  NUM_DIGITS  decimal-point request per digit
ENABLE  input  NUM_DIGITS  per-digit enable; 0 = digit fully dark incl. DP
HEX_MODE  input  1  1 = values 10..15 shown as A b C d E F; 0 = shown blank
LZ_BLANK  input  1  1 = suppress leading zeros
SEGMENT  output  8  bit0=a .. bit6=g, bit7=dp (logical active-high before polarity)
ANODE  output  NUM_DIGITS  digit select, one-hot logical
FRAME_TICK  output  1  one-cycle pulse when a new input snapshot is loaded

Behaviour:
- Reset (async, active-high): div_cnt=0, idx=0, snapshot regs=0 (ENABLE snapshot all 0), FRAME_TICK=0, ANODE all inactive, SEGMENT all off (8'hFF if SEG_ACTIVE_LOW else 8'h00). Outputs reach reset value immediately on RESET assertion, not at next edge.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 then wraps to 0; at terminal count idx advances, NUM_DIGITS-1 wraps to 0.
- Snapshot: at terminal count with idx==NUM_DIGITS-1, DIGITS/DP/ENABLE/HEX_MODE/LZ_BLANK latched into snapshot regs; FRAME_TICK high that same cycle. First frame after reset is therefore fully dark. Input changes between snapshots have no visible effect.
- Glyphs (logical): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Value>=10 with HEX_MODE=0 -> 00.
- Leading-zero blanking (LZ_BLANK=1): scanning from digit NUM_DIGITS-1 downward, enabled digits with value 0 are blanked until the first nonzero enabled digit; disabled digits neither break nor extend the run. Digit 0 is never LZ-blanked. DP still shown on an LZ-blanked digit if requested.
- Output registers: SEGMENT/ANODE are registered from the current idx/div_cnt/snapshot (1-cycle latency). ANODE[idx] active only when div_cnt >= BLANK_CYCLES and snapshot ENABLE[idx]=1; otherwise all inactive. SEGMENT = glyph | (DP<<7) of digit idx, forced off when digit disabled; SEGMENT valid during blank window too (anodes off).
- Polarity inversion applied last, in the output register.
- NUM_DIGITS=1: idx constant 0, snapshot every REFRESH_DIV cycles.

Decomposition:
- Package seven_segment_pkg: glyph constants (SEG_0..SEG_F, SEG_BLANK, SEG_DP bit index), function glyph(value, hex_mode).
- Sub-module seg7_glyph_lut: combinational 4-bit value + hex_mode -> 7-bit glyph; scanner instantiates one, fed by the muxed digit.

Test Plan:
(All: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, both ACTIVE_LOW=1.)
- RESET pulsed mid-slot -> ANODE=4'hF, SEGMENT=8'hFF same cycle; after release, first FRAME_TICK after exactly 32 cycles, then every 32.
- DIGITS=16'h1234, ENABLE=4'hF, DP=4'b0100, decimal -> digit0 slot SEGMENT=~8'h66, ANODE=4'b1110 for 6 of 8 cycles; digit2 slot SEGMENT=~8'hDB.
- DIGITS=16'hABCD, HEX_MODE=1 -> digit0 ~8'h5E, digit3 ~8'h77; HEX_MODE=0 -> all SEGMENT=8'hFF, anodes still scan.
- LZ_BLANK=1, DIGITS=16'h0050 -> digits 3,2 SEGMENT=8'hFF, digit1 ~8'h6D, digit0 ~8'h3F; DIGITS=16'h0000 -> only digit0 shows ~8'h3F.
- Change DIGITS mid-frame -> displayed values unchanged until cycle after next FRAME_TICK.
- ENABLE=4'b0101 -> ANODE[1],ANODE[3] never active, SEGMENT=8'hFF in their slots even with DP set.
